// File: rtl/nes_clk_pkg.sv
// nes_clk_pkg: shared defaults, run/halt state type and counter-width helper for the NES clock enables
package nes_clk_pkg;
    localparam int DEF_CPU_DIV  = 12;
    localparam int DEF_PPU_DIV  = 4;
    localparam int DEF_PHI2_LOW = 5;
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
    function automatic int cnt_width(int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction
endpackage

// File: rtl/nes_clock_enables_ce_divider.sv
// ce_divider: modulo-DIV tick counter; wrap flags the tick on which count returns to 0
//   clk, reset : clock and async active-high reset
//   tick       : advance request
//   count      : current position 0..DIV-1
//   wrap       : combinational, tick while count == DIV-1
module ce_divider #(
    parameter int DIV = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         wrap
);
    assign wrap = tick && (count == W'(DIV - 1));
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (tick) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/nes_clock_enables.sv
// nes_clock_enables: turns the NCO MSB into master/PPU/CPU clock enables with a run/halt/step gate
//   clk, reset : 96 MHz fabric clock, async active-high reset
//   master_in  : NCO accumulator MSB; each rising edge is one master tick
//   run_en     : 1 = CPU free-runs; step_req pulses one CPU cycle while halted
//   master_ce, ppu_ce, cpu_ce, step_ack : single-cycle enables, all aligned one clk after the tick
//   phi2       : CPU phase-2 level; halted : gate is in HALT; cpu_cycles : issued cpu_ce count
module nes_clock_enables
    import nes_clk_pkg::*;
#(
    parameter int CPU_DIV  = DEF_CPU_DIV,
    parameter int PPU_DIV  = DEF_PPU_DIV,
    parameter int PHI2_LOW = DEF_PHI2_LOW,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             master_in,
    input  logic             run_en,
    input  logic             step_req,
    output logic             master_ce,
    output logic             ppu_ce,
    output logic             cpu_ce,
    output logic             phi2,
    output logic             step_ack,
    output logic             halted,
    output logic [CNT_W-1:0] cpu_cycles
);
    localparam int CW = cnt_width(CPU_DIV);
    localparam int PW = cnt_width(PPU_DIV);

    state_t        state, state_next;
    logic          prev_in, tick, ppu_wrap, cpu_wrap;
    logic          step_pending, pend_next, serve, cpu_ce_d, ack_d;
    logic [CW-1:0] cpu_cnt;
    logic [PW-1:0] ppu_cnt_unused;

    // prev_in resets high so a master_in held high through reset is not taken as an edge
    assign tick   = master_in & ~prev_in;
    assign halted = (state == HALT);
    // a step_req on the boundary cycle itself counts as pending for that boundary
    assign serve  = step_pending | (halted & step_req);

    ce_divider #(.DIV(PPU_DIV), .W(PW)) u_ppu_div (
        .clk(clk), .reset(reset), .tick(tick), .count(ppu_cnt_unused), .wrap(ppu_wrap)
    );

    // cpu_cnt runs in every state so CPU/PPU phase survives halts
    ce_divider #(.DIV(CPU_DIV), .W(CW)) u_cpu_div (
        .clk(clk), .reset(reset), .tick(tick), .count(cpu_cnt), .wrap(cpu_wrap)
    );

    always_comb begin
        state_next = state;
        cpu_ce_d   = 1'b0;
        ack_d      = 1'b0;
        pend_next  = serve;
        if (cpu_wrap) begin
            if (run_en) begin
                cpu_ce_d   = 1'b1;
                state_next = RUN;
                pend_next  = 1'b0;
            end else if (state == RUN) begin
                state_next = HALT;
            end else if (serve) begin
                cpu_ce_d  = 1'b1;
                ack_d     = 1'b1;
                pend_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_in      <= 1'b1;
            state        <= RUN;
            step_pending <= 1'b0;
            master_ce    <= 1'b0;
            ppu_ce       <= 1'b0;
            cpu_ce       <= 1'b0;
            step_ack     <= 1'b0;
            phi2         <= 1'b0;
            cpu_cycles   <= '0;
        end else begin
            prev_in      <= master_in;
            state        <= state_next;
            step_pending <= pend_next;
            master_ce    <= tick;
            ppu_ce       <= ppu_wrap;
            cpu_ce       <= cpu_ce_d;
            step_ack     <= ack_d;
            cpu_cycles   <= cpu_cycles + CNT_W'(cpu_ce_d);
            // next count >= PHI2_LOW, written against the pre-tick count (never true on the wrap)
            if (tick)
                phi2 <= (~halted | serve) & ~cpu_wrap & (cpu_cnt >= CW'(PHI2_LOW - 1));
        end
    end
endmodule

// File: tb/tb_nes_clock_enables.sv
// tb_nes_clock_enables: table, hand-sequence and random checks of nes_clock_enables against a tick-count model
module tb_nes_clock_enables;
    localparam int CPU_DIV  = 12;
    localparam int PPU_DIV  = 4;
    localparam int PHI2_LOW = 5;

    logic clk = 1'b0, reset = 1'b1, master_in = 1'b1, run_en = 1'b1, step_req = 1'b0;
    logic master_ce, ppu_ce, cpu_ce, phi2, step_ack, halted;
    logic [15:0] cpu_cycles;
    logic mce4, pce4, cce4, phi24, ack4, halt4;
    logic [3:0] cyc4;

    nes_clock_enables dut (
        .clk(clk), .reset(reset), .master_in(master_in), .run_en(run_en), .step_req(step_req),
        .master_ce(master_ce), .ppu_ce(ppu_ce), .cpu_ce(cpu_ce), .phi2(phi2),
        .step_ack(step_ack), .halted(halted), .cpu_cycles(cpu_cycles)
    );

    nes_clock_enables #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .master_in(master_in), .run_en(run_en), .step_req(step_req),
        .master_ce(mce4), .ppu_ce(pce4), .cpu_ce(cce4), .phi2(phi24),
        .step_ack(ack4), .halted(halt4), .cpu_cycles(cyc4)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int n_mce = 0, n_pce = 0, n_cce = 0, n_ack = 0, n_phi2 = 0;

    bit m_prev, m_halt, m_pend;
    int m_ticks, m_cycles;
    bit e_mce, e_pce, e_cce, e_phi2, e_ack;

    typedef struct {
        bit m;
        bit mce;
        bit pce;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 1'b1; m_halt = 1'b0; m_pend = 1'b0; m_ticks = 0; m_cycles = 0;
        e_mce = 0; e_pce = 0; e_cce = 0; e_phi2 = 0; e_ack = 0;
    endtask

    // ticks are numbered from 1 after reset; tick n sits at position n mod CPU_DIV
    task automatic model(input bit m, input bit r, input bit s);
        bit tick, serve;
        int pos;
        tick = m && !m_prev;
        m_prev = m;
        serve = m_pend || (m_halt && s);
        e_mce = tick; e_pce = 0; e_cce = 0; e_ack = 0;
        if (tick) begin
            m_ticks++;
            pos = m_ticks % CPU_DIV;
            e_pce = (m_ticks % PPU_DIV) == 0;
            e_phi2 = (!m_halt || serve) && pos >= PHI2_LOW;
            if (pos == 0) begin
                if (r) begin e_cce = 1; m_halt = 0; serve = 0; end
                else if (!m_halt) m_halt = 1;
                else if (serve) begin e_cce = 1; e_ack = 1; serve = 0; end
            end
        end
        m_pend = serve;
        if (e_cce) m_cycles = (m_cycles + 1) % 65536;
    endtask

    task automatic cyc(input bit m, input bit r, input bit s);
        master_in = m; run_en = r; step_req = s;
        @(posedge clk);
        model(m, r, s);
        @(negedge clk);
        chk("outputs", 32'({master_ce, ppu_ce, cpu_ce, phi2, step_ack, halted}),
            32'({e_mce, e_pce, e_cce, e_phi2, e_ack, m_halt}));
        chk("outputs_w4", 32'({mce4, pce4, cce4, phi24, ack4, halt4}),
            32'({e_mce, e_pce, e_cce, e_phi2, e_ack, m_halt}));
        chk("cpu_cycles", 32'(cpu_cycles), 32'(m_cycles));
        chk("cpu_cycles_w4", 32'(cyc4), 32'(m_cycles % 16));
        n_mce += int'(master_ce); n_pce += int'(ppu_ce); n_cce += int'(cpu_ce);
        n_ack += int'(step_ack); n_phi2 += int'(phi2);
    endtask

    task automatic sq(input int n, input bit r);
        for (int i = 0; i < n; i++) begin
            cyc(0, r, 0); cyc(0, r, 0); cyc(1, r, 0); cyc(1, r, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int c0, a0, p0, y0;
        tbl = '{'{1,0,0}, '{1,0,0}, '{0,0,0}, '{1,1,0}, '{1,0,0}, '{0,0,0},
                '{1,1,0}, '{0,0,0}, '{1,1,0}, '{0,0,0}, '{1,1,1}, '{1,0,0}};
        repeat (2) @(negedge clk);
        model_reset();
        chk("reset_outputs", 32'({master_ce, ppu_ce, cpu_ce, phi2, step_ack, halted}), 32'd0);
        chk("reset_cycles", 32'(cpu_cycles), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].m, 1, 0);
            chk("table_mce_ppu", 32'({master_ce, ppu_ce}), 32'({tbl[i].mce, tbl[i].pce}));
        end

        do_reset();
        n_mce = 0; n_pce = 0; n_cce = 0; n_phi2 = 0;
        sq(120, 1);
        chk("sq_master_ce", 32'(n_mce), 32'd120);
        chk("sq_ppu_ce", 32'(n_pce), 32'd30);
        chk("sq_cpu_ce", 32'(n_cce), 32'd10);
        chk("sq_phi2_high_clks", 32'(n_phi2), 32'd280);
        chk("sq_cpu_cycles", 32'(cpu_cycles), 32'd10);

        sq(3, 1);
        c0 = n_cce; p0 = n_pce;
        sq(9, 0);
        chk("halt_no_cpu_ce", 32'(n_cce - c0), 32'd0);
        chk("halt_ppu_ce", 32'(n_pce - p0), 32'd3);
        chk("halt_halted", 32'(halted), 32'd1);
        sq(12, 0);
        chk("halt_phi2", 32'(phi2), 32'd0);
        c0 = n_cce;
        sq(12, 1);
        chk("resume_cpu_ce", 32'(n_cce - c0), 32'd1);
        chk("resume_halted", 32'(halted), 32'd0);

        sq(12, 0);
        c0 = n_cce; a0 = n_ack; y0 = int'(cpu_cycles);
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0, k == 2 || k == 5 || k == 8); cyc(0, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
        end
        chk("step_cpu_ce", 32'(n_cce - c0), 32'd1);
        chk("step_ack", 32'(n_ack - a0), 32'd1);
        chk("step_cycles", 32'(cpu_cycles), 32'(y0 + 1));
        c0 = n_cce; a0 = n_ack;
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 0, k == 11);
            if (k == 11) chk("boundary_step", 32'({cpu_ce, step_ack}), 32'd3);
            cyc(1, 0, 0);
        end
        chk("boundary_step_count", 32'(n_cce - c0), 32'd1);

        sq(2, 0);
        cyc(0, 0, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs", 32'({master_ce, ppu_ce, cpu_ce, phi2, step_ack, halted}), 32'd0);
        chk("async_reset_cycles", 32'({cpu_cycles, cyc4}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        c0 = n_cce; a0 = n_ack;
        sq(12, 0);
        chk("post_reset_no_cpu_ce", 32'(n_cce - c0), 32'd0);
        chk("post_reset_no_ack", 32'(n_ack - a0), 32'd0);
        chk("post_reset_halted", 32'(halted), 32'd1);

        c0 = n_mce; y0 = int'(cpu_cycles);
        repeat (40) cyc(1, 1, 0);
        repeat (40) cyc(0, 1, 0);
        chk("stuck_no_tick", 32'(n_mce - c0), 32'd0);
        chk("stuck_cycles_hold", 32'(cpu_cycles), 32'(y0));

        begin
            bit r;
            r = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 199) == 0) r = ~r;
                cyc((i % 500 < 30) ? 1'b1 : (i % 500 < 60) ? 1'b0 : 1'($urandom_range(0, 1)),
                    r, $urandom_range(0, 19) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
